aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Iterative AES-128 encrypt/decrypt controller. It owns the 128-bit state register and the round counter, and drives one combinational round datapath once per clock for 10 rounds. Blocks are accepted and returned over valid/ready handshakes. Round keys come from the key-expansion block as a flat 11-key bus, and the sequencer selects the key for each round.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is legal.
BACK_TO_BACK, 1, 1 = a new block may be accepted in the same cycle the previous result is taken.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
in_valid  in  1  data_in is valid.
in_ready  out  1  sequencer can accept a block.
data_in  in  128  input block; byte 0 = bits [127:120].
key_valid  in  1  round_keys are complete and stable.
round_keys  in  1408  round key i = bits [128*i+127 : 128*i], i = 0..10.
out_valid  out  1  data_out holds a finished block.
out_ready  in  1  consumer takes the result.
data_out  out  128  result block (ciphertext or plaintext).
busy  out  1  rounds in progress; key expansion must not change keys.
round_idx  out  4  current round 1..10; 0 when not running.

Behaviour:
- Reset (asynchronous): FSM=IDLE, state=0, round_idx=0, mode latch=0, out_valid=0, busy=0. in_ready then follows its equation, so it is high only if key_valid=1.
- FSM has three states: IDLE, RUN, DONE.
- in_ready = key_valid & (IDLE | (BACK_TO_BACK & DONE & out_ready)).
- Accept = in_valid & in_ready. On accept the mode is latched and round_idx becomes 1, FSM goes to RUN.
  - Encrypt: state <= data_in ^ rk[0].
  - Decrypt: state <= data_in ^ rk[10].
- RUN, each cycle, r = round_idx:
  - Encrypt key = rk[r]; decrypt key = rk[10-r].
  - Encrypt r<10: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Decrypt r<10: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - r=10: the MixColumns / InvMixColumns step is skipped.
  - r<10: round_idx increments. r=10: FSM goes to DONE, round_idx becomes 0.
- Latency: out_valid rises exactly 10 clocks after the accept edge. Throughput is 1 block per 11 cycles with BACK_TO_BACK=1, otherwise 1 per 12.
- DONE: out_valid=1 and data_out=state. Both hold stable while out_ready=0.
  - out_ready=1 with no accept: FSM goes to IDLE and out_valid drops next cycle.
  - out_ready=1 with a simultaneous accept: the new block is loaded and FSM goes straight to RUN. out_valid drops and busy rises on the same edge.
- busy = (FSM==RUN).
- in_valid while busy or in DONE with out_ready=0 is ignored; in_ready=0 in those cases.
- key_valid deasserting in RUN has no effect on the running block; it only blocks new accepts. round_keys are stable while busy by contract, and the sequencer does not copy them.
- rst mid-operation: the block is discarded, no partial out_valid is produced, and all outputs take reset values immediately.
- data_out outside DONE shows state; consumers qualify it with out_valid.

Decomposition:
- Package aes_pkg holds:
  - typedefs state_t [127:0] and rk_bus_t [1407:0];
  - constants AES_NR=10, MODE_ENC=0, MODE_DEC=1;
  - the FSM state enum;
  - the byte-lane index helper for the key slice.
- Sub-module aes_round_datapath is purely combinational.
  - Inputs: state, key, mode, last.
  - Output: next state.
  - It wraps the existing subbytes/shiftrows/MixColumns/addRoundKey and their inverse primitives.
- The sequencer contains only the FSM, the counter, the registers and the key mux.

Test Plan:
- FIPS-197 App. B: enc, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid 10 cycles after accept, data_out 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f.
  - Enc pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Dec of that ciphertext -> original plaintext.
  - round_idx steps 1..10 in both directions.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> data_out and out_valid stable; in_ready=0; a second in_valid is not accepted.
- Back-to-back: out_ready=1 and in_valid=1 in the DONE cycle -> accept on the same edge; the next result arrives 11 cycles after the previous one; both vectors are correct.
- key_valid=0 in IDLE with in_valid=1 -> no accept and busy stays 0. Raising key_valid -> accept on the next edge.
- Assert rst at round 5 -> outputs clear immediately, no out_valid. After release, the App. B vector runs correctly with no residue from the aborted block.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and key-slice helper for the AES-128 sequencer
package aes_pkg;

  typedef logic [127:0]  state_t;
  typedef logic [1407:0] rk_bus_t;

  localparam int   AES_NR   = 10;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_t;

  // Bit offset of round key idx inside the flat 11-key bus.
  function automatic logic [10:0] rk_lsb(input logic [3:0] idx);
    return 11'(idx) * 11'd128;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// rtl/aes_round_datapath.sv - one combinational AES round, forward or inverse
module aes_round_datapath
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t key,
  input  logic   mode,
  input  logic   last,
  output state_t next
);

  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, bb, acc;
    acc = '0;
    p   = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ p;
      p  = xtime(p);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // Field inverse as a^254 (square-and-multiply); 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = gmul(a, a);
    for (int i = 1; i < 8; i++) begin
      r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  logic [7:0] din [16];
  logic [7:0] kb  [16];
  logic [7:0] sub [16];
  logic [7:0] ak  [16];
  logic [7:0] ob  [16];
  logic [7:0] acc_f, acc_i;

  // Byte k = row + 4*col, byte 0 in the top bits; shift and substitute commute per byte.
  always_comb begin
    acc_f = '0;
    acc_i = '0;
    next  = '0;
    for (int k = 0; k < 16; k++) begin
      din[k] = state[127-8*k -: 8];
      kb[k]  = key[127-8*k -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sub[r+4*c] = mode ? inv_sbox(din[r+4*((c-r+4)%4)]) : sbox(din[r+4*((c+r)%4)]);
      end
    end
    for (int k = 0; k < 16; k++) ak[k] = sub[k] ^ kb[k];
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        acc_f = '0;
        acc_i = '0;
        for (int i = 0; i < 4; i++) begin
          acc_f = acc_f ^ gmul(sub[4*c+i], FWD_COEF[31-8*((i-j+4)%4) -: 8]);
          acc_i = acc_i ^ gmul(ak[4*c+i], INV_COEF[31-8*((i-j+4)%4) -: 8]);
        end
        ob[4*c+j] = last ? ak[4*c+j] : (mode ? acc_i : (acc_f ^ kb[4*c+j]));
      end
    end
    for (int k = 0; k < 16; k++) next[127-8*k -: 8] = ob[k];
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round controller with valid/ready block I/O
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR           = AES_NR,
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   data_in,
  input  logic           key_valid,
  input  logic [1407:0]  round_keys,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   data_out,
  output logic           busy,
  output logic [3:0]     round_idx
);

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t       fsm, fsm_nx;
  state_t     state_q, round_out, key;
  logic       mode_q, accept, last;
  logic [3:0] round_q, key_sel;

  assign accept = in_valid & in_ready;
  assign last   = (round_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= FSM_IDLE;
    else     fsm <= fsm_nx;
  end

  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      FSM_IDLE: if (accept) fsm_nx = FSM_RUN;
      FSM_RUN:  if (last) fsm_nx = FSM_DONE;
      FSM_DONE: begin
        if (accept)         fsm_nx = FSM_RUN;
        else if (out_ready) fsm_nx = FSM_IDLE;
      end
      default:  fsm_nx = FSM_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = key_valid & ((fsm == FSM_IDLE) | (BACK_TO_BACK & (fsm == FSM_DONE) & out_ready));
    out_valid = (fsm == FSM_DONE);
    busy      = (fsm == FSM_RUN);
  end

  // Whitening key on accept uses the incoming mode; rounds use the latched one.
  always_comb begin
    if (accept)                  key_sel = (mode == MODE_DEC) ? LAST : 4'd0;
    else if (mode_q == MODE_DEC) key_sel = LAST - round_q;
    else                         key_sel = round_q;
  end

  assign key = round_keys[rk_lsb(key_sel) +: 128];

  aes_round_datapath u_datapath (
    .state (state_q),
    .key   (key),
    .mode  (mode_q),
    .last  (last),
    .next  (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      round_q <= '0;
      mode_q  <= MODE_ENC;
    end else if (accept) begin
      state_q <= data_in ^ key;
      round_q <= 4'd1;
      mode_q  <= mode;
    end else if (fsm == FSM_RUN) begin
      state_q <= round_out;
      round_q <= last ? 4'd0 : round_q + 4'd1;
    end
  end

  assign data_out  = state_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - scoreboard bench for the AES-128 round sequencer
module tb_aes_round_sequencer;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0, rst = 1'b1, mode = 1'b0, in_valid = 1'b0;
  logic          key_valid = 1'b1, out_ready = 1'b0;
  logic [127:0]  data_in = '0;
  logic [1407:0] round_keys = '0;
  logic          in_ready, out_valid, busy;
  logic [127:0]  data_out;
  logic [3:0]    round_idx;

  int            checks = 0, passed = 0;
  logic [127:0]  exp_q [$];
  logic [7:0]    sbox_m [256];
  logic [1407:0] rk_b, rk_c;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10), .BACK_TO_BACK(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .key_valid  (key_valid),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from the multiply-by-3 / divide-by-3 generator walk.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] bus;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]] ^ rcon, sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    bus = '0;
    for (int r = 0; r < 11; r++) bus[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return bus;
  endfunction

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic send(input logic m, input logic [127:0] d, input logic [127:0] e);
    @(negedge clk);
    mode = m; data_in = d; in_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; mode = ~m; data_in = '0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (round_idx !== 4'd0) $display("FAIL reset_round_idx got %0d want 0", round_idx); else passed++;
    checks++; if (data_out !== 128'd0) $display("FAIL reset_data_out got %h want 0", data_out); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_kv1 got %0b want 1", in_ready); else passed++;
    key_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_kv0 got %0b want 0", in_ready); else passed++;
    key_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enc_b();
    int n;
    round_keys = rk_b;
    send(1'b0, PT_B, CT_B);
    wait_out(n);
    checks++; if (n !== 10) $display("FAIL enc_b_latency got %0d want 10", n); else passed++;
    checks++; if (data_out !== pop_exp()) $display("FAIL enc_b_data got %h want %h", data_out, CT_B); else passed++;
    take();
    checks++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL enc_b_release got %b want 001", {out_valid, busy, in_ready}); else passed++;
  endtask

  task automatic test_rounds(input logic m, input logic [127:0] d, input logic [127:0] e);
    logic [127:0] x;
    round_keys = rk_c;
    send(m, d, e);
    for (int s = 1; s <= 10; s++) begin
      checks++; if ({busy, round_idx} !== {1'b1, 4'(s)}) $display("FAIL rounds_m%0b_idx got %0b/%0d want 1/%0d", m, busy, round_idx, s); else passed++;
      @(negedge clk);
    end
    checks++; if ({out_valid, round_idx} !== 5'b1_0000) $display("FAIL rounds_m%0b_done got %0b/%0d want 1/0", m, out_valid, round_idx); else passed++;
    x = pop_exp();
    checks++; if (data_out !== x) $display("FAIL rounds_m%0b_data got %h want %h", m, data_out, x); else passed++;
    take();
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] e;
    round_keys = rk_c;
    send(1'b0, PT_C, CT_C);
    wait_out(n);
    checks++; if (n !== 10) $display("FAIL bp_latency got %0d want 10", n); else passed++;
    e = pop_exp();
    mode = 1'b0; data_in = PT_B; in_valid = 1'b1;
    repeat (5) begin
      checks++; if ({out_valid, in_ready, busy, data_out} !== {3'b100, e}) $display("FAIL bp_hold got v%0b r%0b b%0b %h want v1 r0 b0 %h", out_valid, in_ready, busy, data_out, e); else passed++;
      @(negedge clk);
    end
    in_valid = 1'b0; data_in = '0;
    take();
    checks++; if ({out_valid, busy, round_idx} !== 6'd0) $display("FAIL bp_no_accept got %b want 000000", {out_valid, busy, round_idx}); else passed++;
  endtask

  task automatic test_back_to_back();
    int n, gap;
    logic [127:0] e;
    round_keys = rk_c;
    send(1'b0, PT_C, CT_C);
    wait_out(n);
    checks++; if (n !== 10) $display("FAIL b2b_first_latency got %0d want 10", n); else passed++;
    e = pop_exp();
    checks++; if (data_out !== e) $display("FAIL b2b_first_data got %h want %h", data_out, e); else passed++;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; data_in = CT_C;
    exp_q.push_back(PT_C);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %0b want 1", in_ready); else passed++;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; mode = 1'b0; data_in = '0;
    checks++; if ({out_valid, busy, round_idx} !== 6'b01_0001) $display("FAIL b2b_reload got %b want 010001", {out_valid, busy, round_idx}); else passed++;
    wait_out(n);
    gap = n + 1;
    checks++; if (gap !== 11) $display("FAIL b2b_spacing got %0d want 11", gap); else passed++;
    e = pop_exp();
    checks++; if (data_out !== e) $display("FAIL b2b_second_data got %h want %h", data_out, e); else passed++;
    take();
  endtask

  task automatic test_key_valid();
    int n;
    logic [127:0] e;
    round_keys = rk_b;
    key_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b0; data_in = PT_B;
    repeat (3) begin
      @(negedge clk);
      checks++; if ({in_ready, busy} !== 2'b00) $display("FAIL kv_blocked got %b want 00", {in_ready, busy}); else passed++;
    end
    key_valid = 1'b1;
    exp_q.push_back(CT_B);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL kv_ready got %0b want 1", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0; data_in = '0;
    checks++; if ({busy, round_idx} !== 5'b1_0001) $display("FAIL kv_accept got %b want 10001", {busy, round_idx}); else passed++;
    wait_out(n);
    checks++; if (n !== 10) $display("FAIL kv_latency got %0d want 10", n); else passed++;
    e = pop_exp();
    checks++; if (data_out !== e) $display("FAIL kv_data got %h want %h", data_out, e); else passed++;
    take();
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw;
    logic [127:0] e;
    round_keys = rk_c;
    send(1'b0, PT_C, CT_C);
    n = 0;
    while (round_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (round_idx !== 4'd5) $display("FAIL rstmid_reach got %0d want 5", round_idx); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, busy, round_idx, data_out} !== 134'd0) $display("FAIL rstmid_clear got v%0b b%0b r%0d %h want all 0", out_valid, busy, round_idx, data_out); else passed++;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) $display("FAIL rstmid_residue got activity=%0b want 0", saw); else passed++;
    round_keys = rk_b;
    send(1'b0, PT_B, CT_B);
    wait_out(n);
    checks++; if (n !== 10) $display("FAIL rstmid_latency got %0d want 10", n); else passed++;
    e = pop_exp();
    checks++; if (data_out !== e) $display("FAIL rstmid_data got %h want %h", data_out, e); else passed++;
    take();
  endtask

  initial begin
    build_sbox();
    rk_b = expand_key(KEY_B);
    rk_c = expand_key(KEY_C);
    round_keys = rk_b;
    test_reset();
    test_enc_b();
    test_rounds(1'b0, PT_C, CT_C);
    test_rounds(1'b1, CT_C, PT_C);
    test_backpressure();
    test_back_to_back();
    test_key_valid();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
